add_byte_serial: RTL and testbench

- Multi-byte adder that adds two NBYTES*8-bit operands one byte per clock, through a single 8-bit carry-lookahead slice.
- The carry is held in a register between bytes, and result bytes are assembled into a sum register.
- Sits directly downstream of operand registers and consumes the 8-bit slice's sum/cout every cycle. It is the sequencing stage that turns the 8-bit adder into a wide, area-cheap adder.
- Start/busy/done handshake to the controller.

---
 rtl/add_byte_serial_pkg.sv | 15 +
 rtl/add8_cla.sv | 37 +++
 rtl/add_byte_serial.sv | 123 ++++++++++++
 tb/tb_add_byte_serial.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/add_byte_serial_pkg.sv
// Shared definitions for the byte-serial adder.
// Contents:
//   state_e : sequencer state encoding (idle / run / done)
//   BYTE_W  : width of one adder slice
package add_byte_serial_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/add8_cla.sv
// Purely combinational 8-bit carry-lookahead adder slice.
// Ports:
//   a_i, b_i : 8-bit addends
//   cin_i    : carry in
//   sum_o    : 8-bit sum
//   cout_o   : carry out of bit 7
module add8_cla (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);

  logic [7:0] gen;
  logic [7:0] prop;
  logic [8:0] carry;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;

  // Carries are built in a procedural loop so no signal depends on itself.
  always_comb begin
    logic c;
    c        = cin_i;
    carry    = '0;
    carry[0] = cin_i;
    for (int i = 0; i < 8; i++) begin
      c            = gen[i] | (prop[i] & c);
      carry[i + 1] = c;
    end
  end

  assign sum_o  = prop ^ carry[7:0];
  assign cout_o = carry[8];

endmodule

// File: rtl/add_byte_serial.sv
// Wide adder that processes one byte per clock through a single 8-bit CLA slice.
// Ports:
//   clk_i    : rising-edge clock
//   rst_ni   : synchronous active-low reset
//   start_i  : request, accepted when not busy
//   a_i, b_i : operands, sampled on the accepting edge
//   cin_i    : carry in, sampled on the accepting edge
//   busy_o   : addition in progress
//   done_o   : one-cycle pulse, results valid from this cycle on
//   sum_o    : result, held until the next accepted start
//   cout_o   : carry out of the MSB
//   ovf_o    : two's-complement signed overflow
module add_byte_serial
  import add_byte_serial_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [BYTE_W*NBYTES-1:0]   a_i,
  input  logic [BYTE_W*NBYTES-1:0]   b_i,
  input  logic                       cin_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [BYTE_W*NBYTES-1:0]   sum_o,
  output logic                       cout_o,
  output logic                       ovf_o
);

  localparam int unsigned W    = BYTE_W * NBYTES;
  localparam int unsigned IdxW = $clog2(NBYTES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [BYTE_W-1:0] slice_a, slice_b, slice_sum;
  logic              slice_cout;

  assign slice_a = a_q[idx_q*BYTE_W +: BYTE_W];
  assign slice_b = b_q[idx_q*BYTE_W +: BYTE_W];

  add8_cla u_slice (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          carry_d = cin_i;
          idx_d   = '0;
          sum_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[idx_q*BYTE_W +: BYTE_W] = slice_sum;
        carry_d = slice_cout;
        if (idx_q == LastIdx) begin
          cout_d  = slice_cout;
          // Overflow: like-signed operands producing a result of the other sign.
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (slice_sum[BYTE_W-1] != a_q[W-1]);
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o = (state_q == StRun);
  assign done_o = (state_q == StDone);
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_add_byte_serial.sv
module tb_add_byte_serial;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         start_i;
  logic [W-1:0] a_i, b_i;
  logic         cin_i;
  logic         busy_o, done_o, cout_o, ovf_o;
  logic [W-1:0] sum_o;

  logic [7:0] ca, cb, cs;
  logic       cc, cco;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Bench-side model of the sequencer.
  int   mst  = 0;  // 0 idle, 1 run, 2 done
  int   mcnt = 0;
  res_t held = '0;
  res_t sb_q[$];

  always #5 clk_i = ~clk_i;

  add_byte_serial #(.NBYTES(NB)) u_dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .cin_i   (cin_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .sum_o   (sum_o),
    .cout_o  (cout_o),
    .ovf_o   (ovf_o)
  );

  add8_cla u_cla (
    .a_i    (ca),
    .b_i    (cb),
    .cin_i  (cc),
    .sum_o  (cs),
    .cout_o (cco)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin);
    logic [W:0] t;
    res_t r;
    t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return r;
  endfunction

  // One clock: update the model from the inputs presented, then check outputs.
  task automatic tick();
    @(posedge clk_i);
    if (!rst_ni) begin
      mst  = 0;
      mcnt = 0;
      held = '0;
      sb_q.delete();
    end else if (mst == 1) begin
      mcnt++;
      if (mcnt == NB) begin
        mst = 2;
        if (sb_q.size() > 0) held = sb_q.pop_front();
      end
    end else if (start_i) begin
      sb_q.push_back(ref_add(a_i, b_i, cin_i));
      held.sum = '0;
      mst      = 1;
      mcnt     = 0;
    end else begin
      mst = 0;
    end
    #1;
    chk("busy", 64'(busy_o), 64'(mst == 1));
    chk("done", 64'(done_o), 64'(mst == 2));
    if (mst != 1) begin
      chk("sum", 64'(sum_o), 64'(held.sum));
      chk("cout", 64'(cout_o), 64'(held.cout));
      chk("ovf", 64'(ovf_o), 64'(held.ovf));
    end
  endtask

  // Accept an addition and run up to its done cycle.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    start_i = 1'b1;
    a_i     = a;
    b_i     = b;
    cin_i   = cin;
    tick();
    start_i = 1'b0;
    a_i     = ~a;
    b_i     = ~b;
    cin_i   = ~cin;
    repeat (NB) tick();
  endtask

  initial begin
    rst_ni  = 1'b0;
    start_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    cin_i   = 1'b0;
    repeat (2) tick();
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_sum", 64'(sum_o), 64'd0);
    rst_ni = 1'b1;
    tick();

    // Carry ripple through every byte.
    op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    chk("ripple_done", 64'(done_o), 64'd1);
    chk("ripple_sum", 64'(sum_o), 64'h0);
    chk("ripple_cout", 64'(cout_o), 64'd1);
    tick();

    op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    chk("ovf_sum", 64'(sum_o), 64'h8000_0000);
    chk("ovf_flag", 64'(ovf_o), 64'd1);
    tick();

    op(32'h1234_5678, 32'h1111_1111, 1'b1);
    chk("cin_sum", 64'(sum_o), 64'h2345_678A);
    tick();

    // Start while busy must be ignored.
    start_i = 1'b1; a_i = 32'h10; b_i = 32'h20; cin_i = 1'b0;
    tick();
    start_i = 1'b0;
    tick();
    start_i = 1'b1; a_i = 32'hFFFF_FFFF;
    tick();
    start_i = 1'b0;
    repeat (NB - 2) tick();
    chk("ign_sum", 64'(sum_o), 64'h30);
    tick();
    tick();

    // Reset while idx=2: abort with no done.
    start_i = 1'b1; a_i = 32'hAAAA_5555; b_i = 32'h5555_AAAB; cin_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (2) tick();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    chk("abort_sum", 64'(sum_o), 64'h0);
    repeat (NB + 2) tick();
    op(32'd5, 32'd7, 1'b0);
    chk("post_rst_sum", 64'(sum_o), 64'd12);

    // Back-to-back: second start presented in the first done cycle.
    op(32'h0000_00FF, 32'h0000_0001, 1'b0);
    chk("b2b_first", 64'(sum_o), 64'h100);
    op(32'h8000_0000, 32'h8000_0000, 1'b0);
    chk("b2b_second", 64'(sum_o), 64'h0);
    chk("b2b_ovf", 64'(ovf_o), 64'd1);
    tick();

    // Random regression with random start pattern and reset pulses.
    for (int i = 0; i < 30000; i++) begin
      start_i = ($urandom_range(0, 3) != 0);
      a_i     = W'({$urandom(), $urandom()});
      b_i     = W'({$urandom(), $urandom()});
      cin_i   = $urandom_range(0, 1) == 1;
      rst_ni  = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_ni  = 1'b1;
    start_i = 1'b0;
    repeat (NB + 2) tick();

    // Exhaustive slice coverage.
    for (int v = 0; v < (1 << 17); v++) begin
      {cc, ca, cb} = 17'(v);
      #1;
      chk("cla", 64'({cco, cs}), 64'({1'b0, ca} + {1'b0, cb} + {8'd0, cc}));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
